// File: rtl/audio_mux_pkg.sv
// Shared definitions for the multi-channel host audio multiplexer:
// register addresses, fill sequencer states and STATUS word layout.
package audio_mux_pkg;

    localparam logic [3:0] ADDR_CH0     = 4'h0;
    localparam logic [3:0] ADDR_CTRL    = 4'h8;
    localparam logic [3:0] ADDR_BUFSIZE = 4'h9;
    localparam logic [3:0] ADDR_SRATE   = 4'hA;
    localparam logic [3:0] ADDR_STATUS  = 4'hB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    localparam int STAT_OVR_LSB   = 24;
    localparam int STAT_STATE_LSB = 16;
    localparam int STAT_CNT_LSB   = 0;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/audio_fill_seq.sv
// Fill sequencer: issues one sample trigger per synth frame until the host
// FIFO holds buffersize frames, and tracks overlapping jack cycles.
module audio_fill_seq
    import audio_mux_pkg::*;
#(
    parameter int FIFO_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  jack_read_act,
    input  logic [FIFO_WIDTH:0]   buffersize,
    input  logic                  xxxx_top,
    input  logic                  run,
    input  logic                  status_rd,
    output logic                  run_trig,
    output fill_state_t           state,
    output logic [FIFO_WIDTH:0]   counter,
    output logic                  overrun,
    output logic [7:0]            overrun_cnt
);

    localparam logic [FIFO_WIDTH:0] ONE = {{FIFO_WIDTH{1'b0}}, 1'b1};

    logic jack_read_act_dly;
    logic cycle_end;
    logic bufsize_zero;
    logic last_trig;

    assign cycle_end    = jack_read_act_dly && !jack_read_act;
    assign bufsize_zero = (buffersize == '0);
    assign last_trig    = run_trig && ((counter + ONE) == buffersize);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jack_read_act_dly <= 1'b0;
            state             <= IDLE;
            counter           <= '0;
            run_trig          <= 1'b0;
            overrun           <= 1'b0;
            overrun_cnt       <= '0;
        end else begin
            jack_read_act_dly <= jack_read_act;
            run_trig          <= 1'b0;
            if (status_rd)
                overrun <= 1'b0;
            if (bufsize_zero) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (cycle_end) begin
                            state   <= FILL;
                            counter <= '0;
                        end
                    end
                    FILL: begin
                        // A new jack cycle restarting mid-fill wins over everything; set beats a STATUS clear.
                        if (cycle_end) begin
                            counter     <= '0;
                            overrun     <= 1'b1;
                            overrun_cnt <= sat_inc8(overrun_cnt);
                            run_trig    <= xxxx_top && !run;
                        end else if (buffersize <= counter) begin
                            state <= DONE;
                        end else if (last_trig) begin
                            state   <= DONE;
                            counter <= counter + ONE;
                        end else begin
                            if (run_trig)
                                counter <= counter + ONE;
                            run_trig <= xxxx_top && !run;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/audio_mux_mc.sv
// Host-side register file and read mux presenting NUM_CH synth channels as
// left-justified 32-bit words, with a fill sequencer or I2S fallback pacing.
module audio_mux_mc
    import audio_mux_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int AUD_BIT_DEPTH = 24,
    parameter int FIFO_WIDTH    = 6
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [3:0]                        address,
    input  logic                              read,
    input  logic                              write,
    input  logic [31:0]                       datain,
    input  logic [NUM_CH*AUD_BIT_DEPTH-1:0]   sound_in,
    input  logic                              xxxx_top,
    input  logic                              lrck,
    input  logic                              run,
    output logic [31:0]                       dataout,
    output logic [NUM_CH-1:0]                 ch_read,
    output logic                              trig,
    output logic                              i2s_enable,
    output logic [31:0]                       samplerate,
    output logic                              fill_busy,
    output logic                              overrun
);

    logic                  jack_read_act_reg;
    logic [FIFO_WIDTH:0]   buffersize_reg;
    logic [31:0]           samplerate_reg;
    logic [31:0]           dataout_reg;
    logic [31:0]           read_mux;
    logic [31:0]           status_word;
    logic [31:0]           ch_word [NUM_CH];
    logic                  status_rd;
    logic                  run_trig;
    fill_state_t           state;
    logic [FIFO_WIDTH:0]   counter;
    logic [7:0]            overrun_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_word[gi] = 32'(sound_in[gi*AUD_BIT_DEPTH +: AUD_BIT_DEPTH]) << (32 - AUD_BIT_DEPTH);
            assign ch_read[gi] = read && (address == 4'(gi));
        end
    endgenerate

    assign status_rd = read && (address == ADDR_STATUS);

    always_comb begin
        status_word = '0;
        status_word[STAT_OVR_LSB +: 8]   = overrun_cnt;
        status_word[STAT_STATE_LSB +: 2] = state;
        status_word[STAT_CNT_LSB +: FIFO_WIDTH+1] = counter;
    end

    // Unpopulated channel slots and write-only registers read back as zero.
    always_comb begin
        read_mux = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (address == (ADDR_CH0 + 4'(k)))
                read_mux = ch_word[k];
        end
        if (address == ADDR_STATUS)
            read_mux = status_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jack_read_act_reg <= 1'b0;
            buffersize_reg    <= '0;
            samplerate_reg    <= '0;
            dataout_reg       <= '0;
        end else begin
            if (write) begin
                case (address)
                    ADDR_CTRL:    jack_read_act_reg <= datain[0];
                    ADDR_BUFSIZE: buffersize_reg    <= datain[FIFO_WIDTH:0];
                    ADDR_SRATE:   samplerate_reg    <= datain;
                    default:      ;
                endcase
            end
            if (read)
                dataout_reg <= read_mux;
        end
    end

    audio_fill_seq #(
        .FIFO_WIDTH (FIFO_WIDTH)
    ) u_fill_seq (
        .clk           (clk),
        .reset         (reset),
        .jack_read_act (jack_read_act_reg),
        .buffersize    (buffersize_reg),
        .xxxx_top      (xxxx_top),
        .run           (run),
        .status_rd     (status_rd),
        .run_trig      (run_trig),
        .state         (state),
        .counter       (counter),
        .overrun       (overrun),
        .overrun_cnt   (overrun_cnt)
    );

    assign i2s_enable = (buffersize_reg == '0);
    assign trig       = i2s_enable ? lrck : run_trig;
    assign fill_busy  = (state == FILL);
    assign dataout    = dataout_reg;
    assign samplerate = samplerate_reg;

endmodule

// File: tb/tb_audio_mux_mc.sv
// Scoreboarded bench for audio_mux_mc: reads push expected words, a monitor
// compares dataout one cycle after each strobe; pacing checks run inline.
module tb_audio_mux_mc;

    localparam int NUM_CH = 4;
    localparam int AUD    = 24;
    localparam int FW     = 6;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [3:0]            address;
    logic                  read;
    logic                  write;
    logic [31:0]           datain;
    logic [NUM_CH*AUD-1:0] sound_in;
    logic                  xxxx_top;
    logic                  lrck;
    logic                  run;
    logic [31:0]           dataout;
    logic [NUM_CH-1:0]     ch_read;
    logic                  trig;
    logic                  i2s_enable;
    logic [31:0]           samplerate;
    logic                  fill_busy;
    logic                  overrun;

    int n_cmp = 0;
    int n_err = 0;
    int trig_cnt = 0;
    logic [31:0] exp_q [$];
    logic [3:0]  addr_q [$];
    logic [31:0] mon_exp;
    logic [3:0]  mon_addr;

    audio_mux_mc #(.NUM_CH(NUM_CH), .AUD_BIT_DEPTH(AUD), .FIFO_WIDTH(FW)) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .datain(datain), .sound_in(sound_in), .xxxx_top(xxxx_top), .lrck(lrck),
        .run(run), .dataout(dataout), .ch_read(ch_read), .trig(trig),
        .i2s_enable(i2s_enable), .samplerate(samplerate), .fill_busy(fill_busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: dataout is valid just after the edge that saw read.
    always @(posedge clk) begin
        if (read && !reset) begin
            #1;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: got %h expected no read", dataout);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_addr = addr_q.pop_front();
                if (dataout !== mon_exp) begin
                    n_err++;
                    $display("FAIL rd_addr_%h: got %h expected %h", mon_addr, dataout, mon_exp);
                end else begin
                    $display("rd addr=%h data=%h", mon_addr, dataout);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (trig === 1'b1) trig_cnt++;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        address = a; datain = d; write = 1'b1;
        tick();
        write = 1'b0;
        $display("wr addr=%h data=%h", a, d);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input logic [3:0] exp_chr);
        address = a; read = 1'b1;
        exp_q.push_back(exp);
        addr_q.push_back(a);
        #1;
        chk("ch_read", 32'(ch_read), 32'(exp_chr));
        tick();
        read = 1'b0;
    endtask

    task automatic pulse_top();
        xxxx_top = 1'b1;
        tick();
        xxxx_top = 1'b0;
        tick();
        tick();
    endtask

    task automatic jack_cycle();
        wr(4'h8, 32'd1);
        wr(4'h8, 32'd0);
        tick();
    endtask

    initial begin
        reset = 1'b1; address = '0; read = 0; write = 0; datain = '0;
        xxxx_top = 0; lrck = 1'b1; run = 0;
        sound_in = {24'hFFFFFF, 24'hABCDEF, 24'h000001, 24'h123456};
        tick(); tick();
        chk("rst_dataout", dataout, 32'h0);
        chk("rst_samplerate", samplerate, 32'h0);
        chk("rst_i2s_enable", 32'(i2s_enable), 32'd1);
        chk("rst_fill_busy", 32'(fill_busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_trig_hi", 32'(trig), 32'd1);
        lrck = 1'b0; #1;
        chk("rst_trig_lo", 32'(trig), 32'd0);
        tick();
        reset = 1'b0;

        // Channel reads and register map holes
        rd(4'h2, 32'hABCDEF00, 4'b0100);
        rd(4'h6, 32'h00000000, 4'b0000);
        rd(4'h0, 32'h12345600, 4'b0001);
        rd(4'h3, 32'hFFFFFF00, 4'b1000);
        tick();
        chk("dataout_hold", dataout, 32'hFFFFFF00);
        rd(4'h8, 32'h00000000, 4'b0000);
        wr(4'hA, 32'd48000);
        chk("samplerate", samplerate, 32'd48000);

        // Fill of 3 frames from five synth frames
        wr(4'h9, 32'd3);
        chk("i2s_off", 32'(i2s_enable), 32'd0);
        jack_cycle();
        chk("fill_enter", 32'(fill_busy), 32'd1);
        trig_cnt = 0;
        pulse_top();
        chk("busy_after_1", 32'(fill_busy), 32'd1);
        pulse_top();
        chk("busy_after_2", 32'(fill_busy), 32'd1);
        pulse_top();
        chk("busy_after_3", 32'(fill_busy), 32'd0);
        pulse_top();
        pulse_top();
        chk("trig_count_3", 32'(trig_cnt), 32'd3);
        rd(4'hB, 32'h00000003, 4'b0000);

        // run gating
        wr(4'h9, 32'd4);
        jack_cycle();
        run = 1'b1; trig_cnt = 0;
        pulse_top();
        pulse_top();
        chk("trig_blocked", 32'(trig_cnt), 32'd0);
        rd(4'hB, 32'h00010000, 4'b0000);
        run = 1'b0;
        pulse_top();
        pulse_top();
        chk("trig_resume", 32'(trig_cnt), 32'd2);
        rd(4'hB, 32'h00010002, 4'b0000);

        // Overlapping jack cycle
        jack_cycle();
        chk("overrun_set", 32'(overrun), 32'd1);
        rd(4'hB, 32'h01010000, 4'b0000);
        chk("overrun_clr", 32'(overrun), 32'd0);
        rd(4'hB, 32'h01010000, 4'b0000);

        // BUFSIZE rewrite below the current count
        wr(4'h9, 32'd5);
        pulse_top();
        pulse_top();
        rd(4'hB, 32'h01010002, 4'b0000);
        wr(4'h9, 32'd2);
        tick();
        chk("shrink_done", 32'(fill_busy), 32'd0);
        rd(4'hB, 32'h01020002, 4'b0000);
        rd(4'hB, 32'h01000002, 4'b0000);

        // I2S fallback forces IDLE
        wr(4'h9, 32'd3);
        jack_cycle();
        chk("fill_again", 32'(fill_busy), 32'd1);
        wr(4'h9, 32'd0);
        tick();
        chk("bs0_idle", 32'(fill_busy), 32'd0);
        chk("bs0_i2s", 32'(i2s_enable), 32'd1);
        for (int i = 0; i < 4; i++) begin
            lrck = i[0];
            #1;
            chk("trig_lrck", 32'(trig), 32'(i[0]));
        end
        lrck = 1'b0;
        tick();

        // Reset in the middle of a fill
        wr(4'h9, 32'd4);
        jack_cycle();
        pulse_top();
        wr(4'hA, 32'h0000BB80);
        rd(4'h1, 32'h00000100, 4'b0010);
        jack_cycle();
        chk("pre_rst_overrun", 32'(overrun), 32'd1);
        xxxx_top = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_dataout", dataout, 32'h0);
        chk("mid_rst_samplerate", samplerate, 32'h0);
        chk("mid_rst_i2s", 32'(i2s_enable), 32'd1);
        chk("mid_rst_busy", 32'(fill_busy), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        chk("mid_rst_trig", 32'(trig), 32'd0);
        tick();
        chk("post_edge_trig", 32'(trig), 32'd0);
        reset = 1'b0;
        xxxx_top = 1'b0;
        rd(4'hB, 32'h00000000, 4'b0000);
        tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/audio_mux_mc.md
# audio_mux_mc

Multi-channel successor to the stereo host-audio multiplexer.
- Presents NUM_CH synth output channels to the host bus as left-justified 32-bit words.
- Holds the host control registers: jack cycle flag, buffer size, sample rate.
- Runs a fill sequencer that issues one sample trigger per synth frame (`xxxx_top`) until the host FIFO holds `buffersize` frames; overlapping jack cycles are counted.
- Sits between the synth voice engine and the host bridge. When `buffersize` is 0 it falls back to I2S pacing from `lrck`.

## Interface
- NUM_CH, 2, audio channels (2..8)
- AUD_BIT_DEPTH, 24, sample width (16..32)
- FIFO_WIDTH, 6, buffersize/counter width minus one
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- address  in  4  register address
- read  in  1  host read strobe
- write  in  1  host write strobe
- datain  in  32  host write data
- sound_in  in  NUM_CH*AUD_BIT_DEPTH  channel samples; channel k at bits [k*AUD_BIT_DEPTH +: AUD_BIT_DEPTH]
- xxxx_top  in  1  synth frame boundary pulse
- lrck  in  1  I2S word clock
- run  in  1  synth busy; no trigger is issued while high
- dataout  out  32  registered read data
- ch_read  out  NUM_CH  one-hot pop strobe, combinational: read && address==k
- trig  out  1  sample trigger
- i2s_enable  out  1  high when buffersize==0
- samplerate  out  32  host-written sample rate
- fill_busy  out  1  sequencer in FILL
- overrun  out  1  sticky; set on a jack cycle end during FILL, cleared by a STATUS read

## Operation
Register map:
- 0x0..0x7: channel k read. Returns sound_in ch k in [31:32-AUD_BIT_DEPTH], lower bits 0. k>=NUM_CH returns 0.
- 0x8 CTRL (W): bit0 = jack_read_act.
- 0x9 BUFSIZE (W): datain[FIFO_WIDTH:0].
- 0xA SRATE (W): samplerate.
- 0xB STATUS (R): {overrun_cnt[7:0] at [31:24], state[1:0] at [17:16], counter at [FIFO_WIDTH:0]}.
- Writes to read-only addresses are ignored; reads of write-only addresses return 0.

Jack cycle end: jack_read_act_dly && !jack_read_act. jack_read_act_dly is registered every cycle.

Sequencer states:
- IDLE
  - cycle end and buffersize!=0 -> FILL, counter<=0.
- FILL
  - run_trig <= xxxx_top && !run, else 0.
  - counter increments on each cycle run_trig is high.
  - counter+1==buffersize on an increment -> DONE.
  - cycle end in FILL: counter<=0, stay FILL, overrun<=1, overrun_cnt saturating +1 (stops at 255).
- DONE
  - one cycle, then -> IDLE. DONE counts as not busy.

Buffer size 0 and rewrites:
- buffersize==0: FSM is forced to IDLE; trig = lrck (combinational); i2s_enable = 1.
- Otherwise trig = run_trig.
- BUFSIZE written during FILL with new value <= counter: -> DONE next cycle.

Simultaneous events:
- A STATUS read that coincides with an overrun event leaves overrun set; set wins.

## Timing
- dataout updates one cycle after the read strobe. It holds its value when not reading.
- ch_read has zero latency.
- run_trig is high one cycle after the qualifying xxxx_top, for as long as xxxx_top is held and run is low.
- Cycle end is detected one cycle after the CTRL write; FILL is entered on the next edge.
- Reset values, applied immediately and asynchronously:
  - Outputs: dataout=0, samplerate=0, trig follows lrck, i2s_enable=1, fill_busy=0, overrun=0.
  - Internal: buffersize=0, jack_read_act=0, counter=0, overrun_cnt=0, state=IDLE.
- Reset mid-FILL aborts with no trigger on the following edge.

## Structure
- Shared package audio_mux_pkg:
  - address constants ADDR_CH0, ADDR_CTRL, ADDR_BUFSIZE, ADDR_SRATE, ADDR_STATUS
  - state enum IDLE/FILL/DONE
  - STATUS field positions
- One sub-module: audio_fill_seq, containing the FSM, counter, run_trig and overrun logic.
- The top module holds the register file and the data read mux.

## Test plan
- NUM_CH=4, ch2=0xABCDEF, read addr 2 -> dataout=0xABCDEF00 next cycle, ch_read=4'b0100 in the strobe cycle; read addr 6 -> 0.
- BUFSIZE=3, CTRL 1 then 0, five xxxx_top pulses with run=0 -> exactly 3 trig pulses, fill_busy falls after the 3rd, STATUS counter=3.
- BUFSIZE=4, xxxx_top with run=1 -> no trig, counter holds; run=0 -> triggers resume.
- Second cycle end after 2 triggers -> counter=0, overrun=1, overrun_cnt=1; STATUS read clears overrun, count stays 1.
- BUFSIZE=0 -> i2s_enable=1, trig tracks lrck toggling; BUFSIZE=5 mid-FILL at counter 2, then BUFSIZE=2 -> DONE, IDLE.
- Assert reset during FILL -> all outputs at reset values within the same cycle, state IDLE.
